// File: rtl/pixel_group_packer.sv
// Packs P_DATA_NUM consecutive pixels into one word for the max-value search block.
// Define PACK_PAD_REPLICATE_EN to pad partial words with their last real pixel instead of zero.
module pixel_group_packer #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_DATA_NUM   = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [P_DATA_WIDTH-1:0]              i_data,
  input  logic                                 i_valid,
  input  logic                                 i_last,
  output logic                                 o_ready,
  output logic [P_DATA_WIDTH*P_DATA_NUM-1:0]   o_data,
  output logic                                 o_valid,
  output logic                                 o_last,
  output logic [$clog2(P_DATA_NUM+1)-1:0]      o_count,
  input  logic                                 i_ready
);

  localparam int DW = P_DATA_WIDTH * P_DATA_NUM;
  localparam int LW = $clog2(P_DATA_NUM);
  localparam int CW = $clog2(P_DATA_NUM + 1);

  typedef enum logic {S_EMPTY, S_FULL} out_state_e;

  out_state_e              state_q, state_d;
  logic [LW-1:0]           lane_q, lane_d;
  logic [DW-1:0]           asm_q, asm_d;
  logic [DW-1:0]           word;
  logic [DW-1:0]           data_q;
  logic [CW-1:0]           count_q;
  logic                    last_q;
  logic                    accept;
  logic                    close;
  logic [P_DATA_WIDTH-1:0] pad;

`ifdef PACK_PAD_REPLICATE_EN
  assign pad = i_data;
`else
  assign pad = '0;
`endif

  assign accept = i_valid && o_ready;
  assign close  = accept && ((lane_q == LW'(P_DATA_NUM - 1)) || i_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (close) state_d = S_FULL;
      S_FULL: begin
        if (close)        state_d = S_FULL;
        else if (i_ready) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    o_valid = (state_q == S_FULL);
    o_ready = (state_q == S_EMPTY) || i_ready;
  end

  // The closing pixel bypasses the assembly register so the word leaves on the same edge.
  always_comb begin
    word   = '0;
    asm_d  = asm_q;
    lane_d = lane_q;
    for (int unsigned l = 0; l < P_DATA_NUM; l++) begin
      if (l < 32'(lane_q))
        word[l*P_DATA_WIDTH +: P_DATA_WIDTH] = asm_q[l*P_DATA_WIDTH +: P_DATA_WIDTH];
      else if (l == 32'(lane_q))
        word[l*P_DATA_WIDTH +: P_DATA_WIDTH] = i_data;
      else
        word[l*P_DATA_WIDTH +: P_DATA_WIDTH] = pad;
    end
    if (accept) begin
      if (close) begin
        asm_d  = '0;
        lane_d = '0;
      end else begin
        for (int unsigned l = 0; l < P_DATA_NUM; l++) begin
          if (l == 32'(lane_q))
            asm_d[l*P_DATA_WIDTH +: P_DATA_WIDTH] = i_data;
        end
        lane_d = lane_q + LW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lane_q  <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      lane_q <= lane_d;
      asm_q  <= asm_d;
      if (close) begin
        data_q  <= word;
        count_q <= CW'(lane_q) + CW'(1);
        last_q  <= i_last;
      end
    end
  end

  assign o_data  = data_q;
  assign o_count = count_q;
  assign o_last  = last_q;

endmodule

// File: tb/tb_pixel_group_packer.sv
// Self-checking bench for pixel_group_packer: fixed vector table, hand sequences and a random run
// against a queue-based reference model of the packing rules.
module tb_pixel_group_packer;

  localparam int W  = 8;
  localparam int N  = 8;
  localparam int DW = W * N;
  localparam int CW = $clog2(N + 1);
`ifdef PACK_PAD_REPLICATE_EN
  localparam bit PAD_REP = 1'b1;
`else
  localparam bit PAD_REP = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  d     = '0;
  logic          v     = 1'b0;
  logic          l     = 1'b0;
  logic          r     = 1'b0;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_last;
  logic [CW-1:0] o_count;

  pixel_group_packer #(.P_DATA_WIDTH(W), .P_DATA_NUM(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  (d),
    .i_valid (v),
    .i_last  (l),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_last  (o_last),
    .o_count (o_count),
    .i_ready (r)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending pixels of the open word and the word currently offered downstream.
  logic [W-1:0]  q[$];
  bit            m_vld  = 1'b0;
  logic [DW-1:0] m_data = '0;
  int            m_cnt  = 0;
  bit            m_last = 1'b0;

  typedef struct {
    logic          v;
    logic [W-1:0]  d;
    logic          l;
    logic          r;
    logic          ev;
    logic [DW-1:0] ed;
    int            ec;
    logic          el;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit            rdy_m;
    logic [DW-1:0] w;
    bit            closed;
    closed = 1'b0;
    rdy_m  = !m_vld || r;
    if (v && rdy_m) begin
      q.push_back(d);
      if (q.size() == N || l) begin
        w = '0;
        for (int k = 0; k < N; k++) begin
          if (k < q.size())  w[k*W +: W] = q[k];
          else if (PAD_REP) w[k*W +: W] = q[q.size()-1];
        end
        m_data = w;
        m_cnt  = q.size();
        m_last = l;
        closed = 1'b1;
        q.delete();
      end
    end
    if (closed)           m_vld = 1'b1;
    else if (m_vld && r)  m_vld = 1'b0;
  endtask

  task automatic step(input logic iv, input logic [W-1:0] id, input logic il, input logic ir);
    v = iv; d = id; l = il; r = ir;
    #1;
    chk("o_ready", DW'(o_ready), DW'(!m_vld || ir));
    @(posedge clk);
    model_edge();
    #1;
    chk("o_valid", DW'(o_valid), DW'(m_vld));
    if (m_vld) begin
      chk("o_data", o_data, m_data);
      chk("o_count", DW'(o_count), DW'(m_cnt));
      chk("o_last", DW'(o_last), DW'(m_last));
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; v = 1'b0; l = 1'b0; r = 1'b0; d = '0;
    #1;
    chk("rst_o_valid", DW'(o_valid), '0);
    chk("rst_o_data", o_data, '0);
    chk("rst_o_count", DW'(o_count), '0);
    chk("rst_o_last", DW'(o_last), '0);
    q.delete();
    m_vld = 1'b0; m_data = '0; m_cnt = 0; m_last = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_o_ready", DW'(o_ready), DW'(1));
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, W'(i + 1), 1'b0, 1'b1, 1'b0, '0, 0, 1'b0};
    tbl[7].ev = 1'b1; tbl[7].ed = 64'h0807060504030201; tbl[7].ec = 8;
    tbl[8]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, '0, 0, 1'b0};
    tbl[9]  = '{1'b1, 8'h20, 1'b0, 1'b1, 1'b0, '0, 0, 1'b0};
`ifdef PACK_PAD_REPLICATE_EN
    tbl[10] = '{1'b1, 8'h30, 1'b1, 1'b1, 1'b1, 64'h3030303030302010, 3, 1'b1};
    tbl[12] = '{1'b1, 8'hAB, 1'b1, 1'b1, 1'b1, 64'hABABABABABABABAB, 1, 1'b1};
`else
    tbl[10] = '{1'b1, 8'h30, 1'b1, 1'b1, 1'b1, 64'h0000000000302010, 3, 1'b1};
    tbl[12] = '{1'b1, 8'hAB, 1'b1, 1'b1, 1'b1, 64'h00000000000000AB, 1, 1'b1};
`endif
    tbl[11] = '{1'b0, 8'h77, 1'b1, 1'b1, 1'b0, '0, 0, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, '0, 0, 1'b0};

    apply_reset();

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
      chk($sformatf("tbl%0d_valid", i), DW'(o_valid), DW'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), o_data, tbl[i].ed);
        chk($sformatf("tbl%0d_count", i), DW'(o_count), DW'(tbl[i].ec));
        chk($sformatf("tbl%0d_last", i), DW'(o_last), DW'(tbl[i].el));
      end
    end

    // 16 pixels at full rate: two words, no stall
    for (int i = 0; i < 16; i++) begin
      step(1'b1, W'(8'h80 + i), 1'b0, 1'b1);
      if (i == 15) chk("b2b_word2", o_data, 64'h8F8E8D8C8B8A8988);
    end

    // Backpressure: hold 5 cycles, then release while a pixel is presented
    for (int i = 0; i < 8; i++) step(1'b1, W'(8'h40 + i), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h55, 1'b0, 1'b0);
      chk("hold_data", o_data, 64'h4746454443424140);
    end
    step(1'b1, 8'h55, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) step(1'b1, W'(8'h60 + i), 1'b0, 1'b1);
    chk("bp_lane0", DW'(o_data[7:0]), DW'(8'h55));
    chk("bp_count", DW'(o_count), DW'(8));

    // Reset while a word is held downstream
    for (int i = 0; i < 8; i++) step(1'b1, W'(8'hA0 + i), 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    apply_reset();

    // Reset after 4 accepted pixels of a partial word
    for (int i = 0; i < 4; i++) step(1'b1, W'(8'hC0 + i), 1'b0, 1'b1);
    apply_reset();
    for (int i = 0; i < 8; i++) step(1'b1, W'(8'hD0 + i), 1'b0, 1'b1);
    chk("post_rst_word", o_data, 64'hD7D6D5D4D3D2D1D0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 9) < 7), W'($urandom), 1'($urandom_range(0, 19) < 3),
           1'($urandom_range(0, 9) < 7));
    step(1'b0, 8'h00, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
